// File: rtl/pll_mode_sequencer.sv
// Cyclone V fractional PLL reconfiguration sequencer: replays a per-mode register table over Avalon-MM and waits for relock.
// Optional macro PLL_RECONFIG_READBACK_EN enables read-after-write verification of every table write.
module pll_mode_sequencer #(
  parameter int NUM_MODES    = 2,
  parameter int NUM_REGS     = 8,
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int BLANK_CYC    = 8,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              i_refclk,
  input  logic              i_rst,
  input  logic [MW-1:0]     i_mode_sel,
  input  logic              i_mode_req,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [MW-1:0]     o_cur_mode,
  input  logic              i_tbl_wr_en,
  input  logic [MW-1:0]     i_tbl_wr_mode,
  input  logic [IW-1:0]     i_tbl_wr_idx,
  input  logic [ADDR_W-1:0] i_tbl_wr_addr,
  input  logic [DATA_W-1:0] i_tbl_wr_data,
  output logic [ADDR_W-1:0] o_mgmt_address,
  output logic              o_mgmt_write,
  output logic [DATA_W-1:0] o_mgmt_writedata,
  output logic              o_mgmt_read,
  input  logic [DATA_W-1:0] i_mgmt_readdata,
  input  logic              i_mgmt_waitrequest,
  input  logic              i_pll_locked
);

  localparam int NS = NUM_MODES * NUM_REGS;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MODE  = 3'd1,
    S_REGS  = 3'd2,
    S_RDBK  = 3'd3,
    S_START = 3'd4,
    S_BLANK = 3'd5,
    S_LOCK  = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  state_t              r_state;
  logic [NS-1:0]       r_valid;
  logic [ADDR_W-1:0]   r_tbl_addr [NS];
  logic [DATA_W-1:0]   r_tbl_data [NS];
  logic                r_lock_meta;
  logic                r_locked_s;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [MW-1:0]       r_cur_mode;
  logic [MW-1:0]       r_mode;
  logic [IW-1:0]       r_idx;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_write;
  logic [TW-1:0]       r_to_cnt;
  logic [BW-1:0]       r_blank_cnt;

  logic                w_tbl_we;
  logic [SW-1:0]       w_wr_slot;
  int                  w_from;
  logic                w_found;
  logic [IW-1:0]       w_next_idx;
  logic [SW-1:0]       w_next_slot;
  state_t              w_adv_state;
  logic [ADDR_W-1:0]   w_adv_addr;
  logic [DATA_W-1:0]   w_adv_data;
  logic                w_timeout;

  assign w_tbl_we  = i_tbl_wr_en && !r_busy && (int'(i_tbl_wr_mode) < NUM_MODES)
                     && (int'(i_tbl_wr_idx) < NUM_REGS);
  assign w_wr_slot = SW'(int'(i_tbl_wr_mode) * NUM_REGS + int'(i_tbl_wr_idx));
  assign w_timeout = (r_to_cnt == TW'(LOCK_TIMEOUT - 1));

  // Valid bits are the only reset part of the table.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_valid <= {NS{1'b0}};
    end else if (w_tbl_we) begin
      r_valid[w_wr_slot] <= 1'b1;
    end
  end

  // Table payload storage, intentionally not reset.
  always_ff @(posedge i_refclk) begin
    if (w_tbl_we) begin
      r_tbl_addr[w_wr_slot] <= i_tbl_wr_addr;
      r_tbl_data[w_wr_slot] <= i_tbl_wr_data;
    end
  end

  // Two-flop synchroniser for the asynchronous lock indication.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_lock_meta <= 1'b0;
      r_locked_s  <= 1'b0;
    end else begin
      r_lock_meta <= i_pll_locked;
      r_locked_s  <= r_lock_meta;
    end
  end

  // Next valid entry search; invalid entries are skipped without costing a cycle.
  always_comb begin
    w_from     = (r_state == S_MODE) ? 0 : int'(r_idx) + 1;
    w_found    = 1'b0;
    w_next_idx = {IW{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!w_found && (i >= w_from) && r_valid[SW'(int'(r_mode) * NUM_REGS + i)]) begin
        w_found    = 1'b1;
        w_next_idx = IW'(i);
      end
    end
    w_next_slot = SW'(int'(r_mode) * NUM_REGS + int'(w_next_idx));
    if (w_found) begin
      w_adv_state = S_REGS;
      w_adv_addr  = r_tbl_addr[w_next_slot];
      w_adv_data  = r_tbl_data[w_next_slot];
    end else begin
      w_adv_state = S_START;
      w_adv_addr  = ADDR_W'(2);
      w_adv_data  = {DATA_W{1'b0}};
    end
  end

`ifdef PLL_RECONFIG_READBACK_EN
  logic r_read;
  assign o_mgmt_read = r_read;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^i_mgmt_readdata;
  assign o_mgmt_read    = 1'b0;
`endif

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge i_refclk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cur_mode  <= {MW{1'b0}};
      r_mode      <= {MW{1'b0}};
      r_idx       <= {IW{1'b0}};
      r_address   <= {ADDR_W{1'b0}};
      r_wdata     <= {DATA_W{1'b0}};
      r_write     <= 1'b0;
      r_to_cnt    <= {TW{1'b0}};
      r_blank_cnt <= {BW{1'b0}};
`ifdef PLL_RECONFIG_READBACK_EN
      r_read      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_mode_req) begin
            if (int'(i_mode_sel) >= NUM_MODES) begin
              r_error <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else if ((i_mode_sel == r_cur_mode) && !r_error) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_mode    <= i_mode_sel;
              r_error   <= 1'b0;
              r_busy    <= 1'b1;
              r_write   <= 1'b1;
              r_address <= {ADDR_W{1'b0}};
              r_wdata   <= {DATA_W{1'b0}};
              r_state   <= S_MODE;
            end
          end
        end
        S_MODE: begin
          if (!i_mgmt_waitrequest) begin
            r_idx     <= w_next_idx;
            r_address <= w_adv_addr;
            r_wdata   <= w_adv_data;
            r_state   <= w_adv_state;
          end
        end
        S_REGS: begin
          if (!i_mgmt_waitrequest) begin
`ifdef PLL_RECONFIG_READBACK_EN
            r_write <= 1'b0;
            r_read  <= 1'b1;
            r_state <= S_RDBK;
`else
            r_idx     <= w_next_idx;
            r_address <= w_adv_addr;
            r_wdata   <= w_adv_data;
            r_state   <= w_adv_state;
`endif
          end
        end
`ifdef PLL_RECONFIG_READBACK_EN
        S_RDBK: begin
          if (!i_mgmt_waitrequest) begin
            r_read <= 1'b0;
            if (i_mgmt_readdata != r_wdata) begin
              r_error <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_write   <= 1'b1;
              r_idx     <= w_next_idx;
              r_address <= w_adv_addr;
              r_wdata   <= w_adv_data;
              r_state   <= w_adv_state;
            end
          end
        end
`endif
        S_START: begin
          if (!i_mgmt_waitrequest) begin
            r_write     <= 1'b0;
            r_to_cnt    <= {TW{1'b0}};
            r_blank_cnt <= {BW{1'b0}};
            r_state     <= S_BLANK;
          end
        end
        S_BLANK: begin
          r_to_cnt <= r_to_cnt + TW'(1);
          if (w_timeout) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else if (r_blank_cnt == BW'(BLANK_CYC - 1)) begin
            r_state <= S_LOCK;
          end else begin
            r_blank_cnt <= r_blank_cnt + BW'(1);
          end
        end
        S_LOCK: begin
          r_to_cnt <= r_to_cnt + TW'(1);
          if (r_locked_s) begin
            r_cur_mode <= r_mode;
            r_error    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= S_FIN;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_write <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_error          = r_error;
  assign o_cur_mode       = r_cur_mode;
  assign o_mgmt_address   = r_address;
  assign o_mgmt_write     = r_write;
  assign o_mgmt_writedata = r_wdata;

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Directed bench for pll_mode_sequencer with a simple Avalon-MM reconfig slave model.
module tb_pll_mode_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode_sel;
  logic        mode_req;
  logic        busy, done, error;
  logic [1:0]  cur_mode;
  logic        tbl_wr_en;
  logic [1:0]  tbl_wr_mode;
  logic [2:0]  tbl_wr_idx;
  logic [5:0]  tbl_wr_addr;
  logic [31:0] tbl_wr_data;
  logic [5:0]  mgmt_address;
  logic        mgmt_write, mgmt_read;
  logic [31:0] mgmt_writedata;
  logic [31:0] mgmt_readdata = 32'd0;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int wait_cycles = 0;
  int hold = 0;
  bit corrupt = 1'b0;
  logic [5:0]  hold_addr;
  logic [31:0] hold_data;
  logic [5:0]  log_addr [$];
  logic [31:0] log_data [$];
  int          log_cyc [$];
  logic [31:0] mem [64];
  int g_start, g_lock, g_done;

  logic [5:0]  exp_a [5] = '{6'd0, 6'd3, 6'd4, 6'd7, 6'd2};
  logic [31:0] exp_d [5] = '{32'h0, 32'h0000_0404, 32'h0002_0000, 32'h1480_0000, 32'h0};

`ifdef PLL_RECONFIG_READBACK_EN
  localparam int GAP1 = 0;
  localparam int GAP4 = 0;
`else
  localparam int GAP1 = 1;
  localparam int GAP4 = 4;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pll_mode_sequencer #(.NUM_MODES(3), .LOCK_TIMEOUT(100)) dut (
    .i_refclk(clk), .i_rst(rst), .i_mode_sel(mode_sel), .i_mode_req(mode_req),
    .o_busy(busy), .o_done(done), .o_error(error), .o_cur_mode(cur_mode),
    .i_tbl_wr_en(tbl_wr_en), .i_tbl_wr_mode(tbl_wr_mode), .i_tbl_wr_idx(tbl_wr_idx),
    .i_tbl_wr_addr(tbl_wr_addr), .i_tbl_wr_data(tbl_wr_data),
    .o_mgmt_address(mgmt_address), .o_mgmt_write(mgmt_write),
    .o_mgmt_writedata(mgmt_writedata), .o_mgmt_read(mgmt_read),
    .i_mgmt_readdata(mgmt_readdata), .i_mgmt_waitrequest(mgmt_waitrequest),
    .i_pll_locked(pll_locked)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Slave model: stretches writes by wait_cycles, checks hold stability, logs accepted writes.
  always @(negedge clk) begin
    if (mgmt_write) begin
      if (hold == 0) begin
        hold_addr = mgmt_address;
        hold_data = mgmt_writedata;
      end else begin
        check_eq("hold_addr", 32'(mgmt_address), 32'(hold_addr));
        check_eq("hold_data", mgmt_writedata, hold_data);
      end
      if (hold < wait_cycles) begin
        mgmt_waitrequest = 1'b1;
        hold++;
      end else begin
        mgmt_waitrequest = 1'b0;
        log_addr.push_back(mgmt_address);
        log_data.push_back(mgmt_writedata);
        log_cyc.push_back(cyc);
        mem[mgmt_address] = mgmt_writedata;
        hold = 0;
      end
    end else if (mgmt_read) begin
      mgmt_waitrequest = 1'b0;
      mgmt_readdata = mem[mgmt_address] + ((corrupt && mgmt_address == 6'd4) ? 32'd1 : 32'd0);
      hold = 0;
    end else begin
      mgmt_waitrequest = 1'b0;
      hold = 0;
    end
  end

  task automatic tbl_load(input logic [1:0] m, input logic [2:0] idx, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    tbl_wr_en = 1'b1; tbl_wr_mode = m; tbl_wr_idx = idx; tbl_wr_addr = a; tbl_wr_data = d;
    @(negedge clk);
    tbl_wr_en = 1'b0;
  endtask

  // Returns at the first negedge after the accepting edge.
  task automatic request(input logic [1:0] m);
    @(negedge clk);
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    mode_sel = m; mode_req = 1'b1;
    @(negedge clk);
    mode_req = 1'b0;
  endtask

  task automatic wait_done(input int lock_delay);
    bit seen = 1'b0;
    g_start = -1; g_lock = -1; g_done = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (g_start < 0)
        for (int j = 0; j < log_addr.size(); j++)
          if (log_addr[j] == 6'd2) g_start = log_cyc[j];
      if (lock_delay >= 0 && g_start >= 0 && g_lock < 0 && (cyc - g_start) >= lock_delay) begin
        pll_locked = 1'b1;
        g_lock = cyc;
      end
      if (done) begin
        seen = 1'b1;
        g_done = cyc;
        break;
      end
    end
    check_eq("done_seen", 32'(seen), 32'd1);
    check_eq("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic check_log(input string tag, input int gap);
    check_eq({tag, "_len"}, 32'(log_addr.size()), 32'd5);
    if (log_addr.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check_eq({tag, "_addr"}, 32'(log_addr[i]), 32'(exp_a[i]));
        check_eq({tag, "_data"}, log_data[i], exp_d[i]);
        if (gap > 0 && i > 0) check_eq({tag, "_gap"}, 32'(log_cyc[i] - log_cyc[i-1]), 32'(gap));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found;
    int n2;
    rst = 1'b1; mode_sel = 2'd0; mode_req = 1'b0; tbl_wr_en = 1'b0; tbl_wr_mode = 2'd0;
    tbl_wr_idx = 3'd0; tbl_wr_addr = 6'd0; tbl_wr_data = 32'd0; pll_locked = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_cur_mode", 32'(cur_mode), 32'd0);
    check_eq("rst_write", 32'(mgmt_write), 32'd0);
    check_eq("rst_read", 32'(mgmt_read), 32'd0);
    check_eq("rst_addr", 32'(mgmt_address), 32'd0);
    check_eq("rst_wdata", mgmt_writedata, 32'd0);
    rst = 1'b0;

    tbl_load(2'd1, 3'd0, 6'd3, 32'h0000_0404);
    tbl_load(2'd1, 3'd2, 6'd4, 32'h0002_0000);
    tbl_load(2'd1, 3'd5, 6'd7, 32'h1480_0000);
    tbl_load(2'd0, 3'd1, 6'd3, 32'h0000_0404);
    tbl_load(2'd0, 3'd3, 6'd4, 32'h0002_0000);
    tbl_load(2'd0, 3'd7, 6'd7, 32'h1480_0000);

    // Basic switch to mode 1, zero wait states.
    request(2'd1);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_mode_wr", 32'(mgmt_write), 32'd1);
    check_eq("t1_mode_addr", 32'(mgmt_address), 32'd0);
    wait_done(20);
    check_log("t1", GAP1);
    check_eq("t1_lock_lat", 32'(g_done - g_lock), 32'd3);
    check_eq("t1_cur_mode", 32'(cur_mode), 32'd1);
    check_eq("t1_error", 32'(error), 32'd0);
    @(negedge clk);
    check_eq("t1_done_1cyc", 32'(done), 32'd0);

    // Same-mode request: immediate done, no traffic.
    request(2'd1);
    check_eq("t2_done", 32'(done), 32'd1);
    check_eq("t2_busy", 32'(busy), 32'd0);
    check_eq("t2_write", 32'(mgmt_write), 32'd0);
    @(negedge clk);
    check_eq("t2_done_off", 32'(done), 32'd0);
    check_eq("t2_busy2", 32'(busy), 32'd0);
    check_eq("t2_nowr", 32'(log_addr.size()), 32'd0);

    // Mode 0 with three wait states on every write.
    pll_locked = 1'b0; wait_cycles = 3;
    request(2'd0);
    wait_done(20);
    check_log("t3", GAP4);
    check_eq("t3_cur_mode", 32'(cur_mode), 32'd0);
    check_eq("t3_error", 32'(error), 32'd0);
    wait_cycles = 0;

    // Lock never arrives.
    pll_locked = 1'b0;
    request(2'd1);
    wait_done(-1);
    check_eq("t4_timeout_lat", 32'(g_done - g_start), 32'd101);
    check_eq("t4_error", 32'(error), 32'd1);
    check_eq("t4_cur_mode", 32'(cur_mode), 32'd0);

    // Out-of-range mode is rejected.
    request(2'd3);
    check_eq("t5_done", 32'(done), 32'd1);
    check_eq("t5_busy", 32'(busy), 32'd0);
    check_eq("t5_error", 32'(error), 32'd1);
    @(negedge clk);
    check_eq("t5_done_off", 32'(done), 32'd0);
    check_eq("t5_error_hold", 32'(error), 32'd1);
    check_eq("t5_nowr", 32'(log_addr.size()), 32'd0);

    // Error set: requesting the current mode runs a full sequence.
    request(2'd0);
    check_eq("t6_busy", 32'(busy), 32'd1);
    check_eq("t6_err_clr", 32'(error), 32'd0);
    wait_done(20);
    check_eq("t6_len", 32'(log_addr.size()), 32'd5);
    check_eq("t6_error", 32'(error), 32'd0);
    check_eq("t6_cur_mode", 32'(cur_mode), 32'd0);

    // Reset during the second table write.
    request(2'd1);
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (mgmt_write && mgmt_address == 6'd4) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check_eq("t7_found", 32'(found), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t7_write", 32'(mgmt_write), 32'd0);
    check_eq("t7_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    request(2'd1);
    wait_done(0);
    check_eq("t7_len", 32'(log_addr.size()), 32'd2);
    if (log_addr.size() == 2) begin
      check_eq("t7_addr0", 32'(log_addr[0]), 32'd0);
      check_eq("t7_addr1", 32'(log_addr[1]), 32'd2);
    end
    check_eq("t7_cur_mode", 32'(cur_mode), 32'd1);

`ifdef PLL_RECONFIG_READBACK_EN
    // Readback mismatch on address 4 aborts before START.
    tbl_load(2'd0, 3'd1, 6'd3, 32'h0000_0404);
    tbl_load(2'd0, 3'd3, 6'd4, 32'h0002_0000);
    tbl_load(2'd0, 3'd7, 6'd7, 32'h1480_0000);
    corrupt = 1'b1;
    request(2'd0);
    wait_done(20);
    n2 = 0;
    for (int j = 0; j < log_addr.size(); j++) if (log_addr[j] == 6'd2) n2++;
    check_eq("t8_no_start", 32'(n2), 32'd0);
    check_eq("t8_error", 32'(error), 32'd1);
    check_eq("t8_cur_mode", 32'(cur_mode), 32'd1);
    corrupt = 1'b0;
`else
    n2 = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pll_mode_sequencer.md
# pll_mode_sequencer

Parametrised reconfiguration sequencer for the Cyclone V fractional PLL. It sits between the core's video-standard control and the PLL reconfig management slave (Avalon-MM, waitrequest mode). On request it replays a stored per-mode register table (M/N/C counters, fractional K, bandwidth) and triggers the update. It then waits for relock, so PAL/NTSC and other clock sets switch at run time without a new bitstream.

## Interface
- NUM_MODES, 2, number of stored clock configurations (≥2).
- NUM_REGS, 8, table entries per mode.
- ADDR_W, 6, management address width.
- DATA_W, 32, management data width.
- LOCK_TIMEOUT, 65535, cycles allowed for relock after start.
- BLANK_CYC, 8, cycles `pll_locked` is ignored after the start write.

Ports:
- refclk  in  1  management clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode_sel  in  MW=max(1,$clog2(NUM_MODES))  requested mode.
- mode_req  in  1  single-cycle request strobe.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse, success or error.
- error  out  1  last sequence failed; held until next accepted request.
- cur_mode  out  MW  last successfully applied mode.
- tbl_wr_en  in  1  table write strobe.
- tbl_wr_mode  in  MW  table mode index.
- tbl_wr_idx  in  $clog2(NUM_REGS)  entry index.
- tbl_wr_addr  in  ADDR_W  PLL register address for entry.
- tbl_wr_data  in  DATA_W  value for entry.
- mgmt_address  out  ADDR_W  to PLL reconfig.
- mgmt_write  out  1.
- mgmt_writedata  out  DATA_W.
- mgmt_read  out  1.
- mgmt_readdata  in  DATA_W.
- mgmt_waitrequest  in  1.
- pll_locked  in  1  asynchronous PLL lock.

## Operation
- Table: NUM_MODES×NUM_REGS entries of {valid, addr, data}. Reset clears all valid bits; addr/data are not reset. A table write sets valid. `tbl_wr_en` while `busy` is ignored.
- `pll_locked` passes through a 2-flop synchroniser (`locked_s`).
- FSM states:
  - IDLE: `mode_req` accepted only here.
  - MODE: write addr 0 = 0, selecting waitrequest mode.
  - REGS: write each valid entry of the selected mode, index 0 upward. Invalid entries are skipped in zero cycles.
  - START: write addr 2 = 0.
  - BLANK: count BLANK_CYC cycles.
  - LOCK: wait for `locked_s`=1.
  - FIN: pulse `done`, return to IDLE.
- Bus rule: `mgmt_write`/`mgmt_read` with address and data are held stable until the rising edge where `mgmt_waitrequest`=0. At most one of write or read is high at a time.
- Same-mode request (`mode_sel`==`cur_mode` and `error`=0): no bus traffic. `busy` stays low and `done` pulses the next cycle.
- `mode_sel` ≥ NUM_MODES: rejected. `error`=1, `done` pulses the next cycle, no bus traffic.
- Lock timeout: the counter starts in BLANK. If LOCK_TIMEOUT cycles elapse without `locked_s`, the block sets `error` and goes to FIN. `cur_mode` is unchanged.
- Success: `cur_mode`←`mode_sel` latched at acceptance, `error`←0.
- `mode_req` while `busy`: ignored, not queued.
- `rst` mid-sequence: next edge returns to IDLE and drops `mgmt_write`/`mgmt_read`. A partially written PLL stays as left.

## Timing
- Reset values: `busy`=0, `done`=0, `error`=0, `cur_mode`=0, `mgmt_write`=0, `mgmt_read`=0, `mgmt_address`=0, `mgmt_writedata`=0.
- Request accepted at edge N: at N+1, `busy`=1 and the MODE write is on the bus.
- With `mgmt_waitrequest` stuck low, each write takes 1 cycle. Total bus phase = 2 + valid-entry count cycles.
- `done` is high for exactly one cycle. `busy` falls in the same cycle `done` rises.
- Lock detect latency: 2 cycles (synchroniser) after `pll_locked` rises, plus 1 cycle to FIN.

## Configuration
- PLL_RECONFIG_READBACK_EN defined: after each REGS write, read the same address, holding `mgmt_read` until waitrequest=0. Compare `mgmt_readdata` with the written data. On mismatch: set `error`, skip START, go to FIN.
- Undefined: no read cycles, `mgmt_read` is constant 0, and `mgmt_readdata` is unused.

## Test plan
- Load mode 1 with 3 valid entries (addr 3 = 0x0000_0404, 4 = 0x0002_0000, 7 = 0x1480_0000), waitrequest=0, lock rising 20 cycles after START → writes addr 0, 3, 4, 7, 2 on consecutive cycles; `done` pulse; `cur_mode`=1; `error`=0.
- Same run with waitrequest high 3 cycles on every write → each write is held 4 cycles with address/data stable; final result identical.
- Request mode 1 again after success → no `mgmt_write`; `done` at N+1; `busy` never high.
- `pll_locked` held 0, LOCK_TIMEOUT=100 → `error`=1 and `done` 100 cycles after BLANK starts; `cur_mode` unchanged.
- Assert `rst` during the second REGS write → `mgmt_write`=0 and `busy`=0 next cycle; all valid bits cleared; a new request writes only addr 0 and 2.
- With PLL_RECONFIG_READBACK_EN, readback of addr 4 returns 0x0002_0001 → `error`=1; no addr 2 write; `done` pulses.
